pipe_stall_ctrl: RTL
====================

Name: pipe_stall_ctrl

Overview:
- Central pipeline sequencer for the 5-stage core (PC/IF/ID/EX/MEM/WB).
- Collects three hold requests and emits one per-stage stall vector:
  - ID load-use hazard
  - EX multi-cycle MULT/MULTU occupancy
  - MEM memory handshake wait
- Gates the ID branch redirect so a held instruction never redirects the PC.
- Owns the MULT occupancy counter; the EX datapath only pulses its start.

Parameters:
- MULT_CYCLES, 4, total cycles a MULT/MULTU occupies EX (≥1).
- WDOG_CYCLES, 255, memory-wait cycles before timeout (only with MEM_WATCHDOG_EN).

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset; synchronous, active-high
- i_id_readEnableLeft  in  1  ID reads rs
- i_id_readEnableRight  in  1  ID reads rt
- i_id_rs  in  5  ID rs address
- i_id_rt  in  5  ID rt address
- i_id_takeBranch  in  1  ID branch/jump decision
- i_ex_isLoad  in  1  EX holds a load
- i_ex_dest  in  5  EX destination register
- i_ex_multStart  in  1  EX holds MULT/MULTU (level, stays high while held)
- i_mem_req  in  1  MEM access in progress
- i_mem_ack  in  1  memory completes access this cycle
- o_stall  out  6  hold per stage: bit0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB
- o_takeBranch  out  1  gated branch redirect to PC
- o_exBusy  out  1  multiply counter nonzero
- o_memTimeout  out  1  sticky memory-wait timeout flag

Behaviour:
- Reset: cnt=0, watchdog=0, o_memTimeout=0. While i_rst=1, o_stall=0, o_takeBranch=0, o_exBusy=0.
- loaduse = i_ex_isLoad & (i_ex_dest≠0) & ((i_id_readEnableLeft & i_id_rs==i_ex_dest) | (i_id_readEnableRight & i_id_rt==i_ex_dest)). Combinational.
- Multiply counter cnt (width clog2(MULT_CYCLES)+1):
  - cnt==0 & i_ex_multStart: exwait = (MULT_CYCLES>1); next cnt = MULT_CYCLES-1.
  - cnt>1: exwait=1; cnt decrements.
  - cnt==1: exwait=0; cnt→0, so the instruction leaves EX at this edge.
  - i_ex_multStart is ignored while cnt≠0.
  - cnt decrements regardless of memory wait. EX stays held by memwait if that is active.
- memwait = i_mem_req & ~i_mem_ack. Combinational.
- o_stall uses deepest-wins priority. Bubble enters the stage after the highest held stage.
  - memwait → 011111
  - else exwait → 001111
  - else loaduse → 000111
  - else → 000000
  - Bit 5 is always 0.
- o_takeBranch = i_id_takeBranch & ~o_stall[2].
- o_exBusy = (cnt≠0). Registered-state derived.
- Zero-latency combinational stall. The only state is cnt (plus watchdog).
- Simultaneous loaduse+exwait: exwait mask covers both. Both clear independently.
- Reset mid-multiply clears cnt immediately. The next cycle has no stall.

Optional Feature:
MEM_WATCHDOG_EN:
- Defined:
  - wdog counter increments each memwait cycle and clears when memwait=0.
  - When wdog reaches WDOG_CYCLES, o_memTimeout is set. It stays set until i_rst.
  - The counter saturates there.
- Undefined: no counter; o_memTimeout tied 0.

Decomposition:
- Shared package holds:
  - stall bit indices STALL_PC..STALL_WB, STALL_BUS width 6
  - REG_ZERO
  - the four mask constants
- One sub-module, mult_occupancy_ctr: cnt, exwait, o_exBusy, parameterised by MULT_CYCLES.

Test Plan:
- Load-use: i_ex_isLoad=1, i_ex_dest=5, i_id_rs=5, i_id_readEnableLeft=1, i_id_takeBranch=1 → o_stall=000111, o_takeBranch=0; i_ex_dest=0 → o_stall=0.
- MULT_CYCLES=4: i_ex_multStart held high → o_stall=001111 for 3 cycles, then 000000 on cycle 4; o_exBusy high cycles 2–4.
- MULT_CYCLES=1: i_ex_multStart=1 → o_stall never asserted, o_exBusy stays 0.
- Memory wait during multiply: i_mem_req=1, ack low 6 cycles while cnt=3 → o_stall=011111 throughout; cnt reaches 0; release one cycle after ack.
- i_rst asserted while cnt=2 → next cycle o_stall=0, o_exBusy=0.
- MEM_WATCHDOG_EN, WDOG_CYCLES=8: req high, ack low 10 cycles → o_memTimeout rises after 8th wait cycle and stays high after ack, until i_rst.

Source files
------------

// File: rtl/pipe_stall_ctrl_pkg.sv
// rtl/pipe_stall_ctrl_pkg.sv - stall bus layout, register-zero constant and per-hazard stall masks
package pipe_stall_ctrl_pkg;

  localparam int STALL_BUS = 6;
  localparam int STALL_PC  = 0;
  localparam int STALL_IF  = 1;
  localparam int STALL_ID  = 2;
  localparam int STALL_EX  = 3;
  localparam int STALL_MEM = 4;
  localparam int STALL_WB  = 5;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Each mask holds every stage up to and including the requesting one.
  localparam logic [STALL_BUS-1:0] MASK_NONE    = 6'b000000;
  localparam logic [STALL_BUS-1:0] MASK_LOADUSE = 6'b000111;
  localparam logic [STALL_BUS-1:0] MASK_EX      = 6'b001111;
  localparam logic [STALL_BUS-1:0] MASK_MEM     = 6'b011111;

endpackage

// File: rtl/pipe_stall_ctrl_mult.sv
// rtl/pipe_stall_ctrl_mult.sv - mult_occupancy_ctr: counts MULT/MULTU occupancy of EX
module mult_occupancy_ctr #(
  parameter int MULT_CYCLES = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_start,
  output logic o_exwait,
  output logic o_busy
);

  localparam int CW = $clog2(MULT_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LOAD   = CW'(MULT_CYCLES - 1);
  localparam logic          START_WAIT = (MULT_CYCLES > 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // A start seen while the counter is running belongs to the same instruction.
  always_comb begin
    cnt_d    = cnt_q;
    o_exwait = 1'b0;
    if (cnt_q == '0) begin
      if (i_start) begin
        cnt_d    = CNT_LOAD;
        o_exwait = START_WAIT;
      end
    end else begin
      cnt_d    = cnt_q - CNT_ONE;
      o_exwait = (cnt_q > CNT_ONE);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_busy = (cnt_q != '0) & ~i_rst;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// rtl/pipe_stall_ctrl.sv - pipeline stall sequencer; MEM_WATCHDOG_EN adds a sticky memory-wait timeout
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = 4,
  parameter int WDOG_CYCLES = 255
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_id_readEnableLeft,
  input  logic                 i_id_readEnableRight,
  input  logic [4:0]           i_id_rs,
  input  logic [4:0]           i_id_rt,
  input  logic                 i_id_takeBranch,
  input  logic                 i_ex_isLoad,
  input  logic [4:0]           i_ex_dest,
  input  logic                 i_ex_multStart,
  input  logic                 i_mem_req,
  input  logic                 i_mem_ack,
  output logic [STALL_BUS-1:0] o_stall,
  output logic                 o_takeBranch,
  output logic                 o_exBusy,
  output logic                 o_memTimeout
);

  logic loaduse;
  logic memwait;
  logic exwait;

  assign loaduse = i_ex_isLoad & (i_ex_dest != REG_ZERO) &
                   ((i_id_readEnableLeft  & (i_id_rs == i_ex_dest)) |
                    (i_id_readEnableRight & (i_id_rt == i_ex_dest)));

  assign memwait = i_mem_req & ~i_mem_ack;

  mult_occupancy_ctr #(
    .MULT_CYCLES(MULT_CYCLES)
  ) u_mult (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_start (i_ex_multStart),
    .o_exwait(exwait),
    .o_busy  (o_exBusy)
  );

  // Deepest requester wins; its mask already covers every shallower hold.
  always_comb begin
    o_stall = MASK_NONE;
    if (!i_rst) begin
      if (memwait) begin
        o_stall = MASK_MEM;
      end else if (exwait) begin
        o_stall = MASK_EX;
      end else if (loaduse) begin
        o_stall = MASK_LOADUSE;
      end
    end
  end

  assign o_takeBranch = i_id_takeBranch & ~o_stall[STALL_ID] & ~i_rst;

`ifdef MEM_WATCHDOG_EN
  localparam int WW = $clog2(WDOG_CYCLES + 1);
  localparam logic [WW-1:0] WDOG_MAX = WW'(WDOG_CYCLES);
  localparam logic [WW-1:0] WDOG_ONE = WW'(1);

  logic [WW-1:0] wdog_q;
  logic [WW-1:0] wdog_d;
  logic          timeout_q;
  logic          timeout_d;

  // Counter saturates at the limit; the flag only clears through reset.
  always_comb begin
    wdog_d    = '0;
    timeout_d = timeout_q;
    if (memwait) begin
      wdog_d = (wdog_q == WDOG_MAX) ? wdog_q : wdog_q + WDOG_ONE;
      if (wdog_d == WDOG_MAX) begin
        timeout_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wdog_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      wdog_q    <= wdog_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_memTimeout = timeout_q;
`else
  logic unused_wdog_cfg;
  assign unused_wdog_cfg = (WDOG_CYCLES != 0);
  assign o_memTimeout    = 1'b0;
`endif

endmodule
